id_decode_pipe: RTL and testbench
=================================

# id_decode_pipe

Registered, multi-lane ID-stage decoder for the MIPS pipeline. Each lane decodes one 32-bit instruction into the 11-bit main-control word, `hilo_we`, `cp0we` and an invalid-instruction flag, then registers them into the ID/EX boundary with stall/flush control. A shared-divider handshake FSM holds the pipeline while a DIV/DIVU in EX is serviced.

## Interface
Parameters:
- `LANES`, default 1: decode lanes per issue group, legal 1..4.

Ports:
- `clk` in, 1: the single clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `instrD` in, LANES*32: lane i is bits [32i+31:32i].
- `validD` in, LANES: lane i holds a real instruction.
- `stallD` in, 1: hazard-unit stall; E registers hold.
- `flushE` in, 1: E registers cleared next edge.
- `controlE` out, LANES*11: per lane {regwrite, regdst, alusrc, branch, memen, memtoreg, jump, jal, jr, bal, memwrite}.
- `hilo_weE` out, LANES*2: per lane {hi_we, lo_we}.
- `cp0weE` out, LANES: MTC0 write enable.
- `invalidE` out, LANES: reserved-instruction flag.
- `validE` out, LANES: registered `validD`.
- `div_start` out, 1: request to the divider.
- `div_signed` out, 1: 1 for DIV, 0 for DIVU; meaningful while `div_start` is 1.
- `div_ready` in, 1: divider accepted the request.
- `div_done` in, 1: one-cycle pulse when the result is written to HI/LO.
- `div_abort` out, 1: one-cycle pulse cancelling an in-flight divide.
- `div_stall` out, 1: to the hazard unit; freezes IF/ID and ID/EX.

## Operation
Per-lane decode (combinational):
- Instruction classes use the team control encodings:
  - R-type ALU: 11'b11000000000.
  - MTHI: hilo 10. MTLO: hilo 01. MULT/MULTU/DIV/DIVU: hilo 11.
  - JR: 11'b00000010100. JALR: 11'b11000000100.
  - Loads: 11'b10101100000. Stores: 11'b00101000001.
  - BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ: 11'b00010000000.
  - BLTZAL/BGEZAL: 11'b10010000010.
  - I-type ALU and LUI: 11'b10100000000.
  - J: 11'b00000010000. JAL: 11'b10000001000.
  - MFC0: 11'b10000000000. MTC0 and ERET: 11'b00000000000.
  - SYSCALL/BREAK: 11'b00000000000, `hilo_we` 00.
- Any unlisted op, funct, REGIMM rt or COP0 rs sets invalid=1, with control and `hilo_we` forced to 0.
- `cp0we`=1 only when op=COP0 and rs=MTC0.
- If `validD[i]`=0, all lane-i decode outputs are forced to 0.
- Multiple DIV/DIVU in one group: the lowest-index lane is served. Every later DIV/DIVU lane in that group gets invalid=1 and all its other decode outputs forced to 0.

E registers (priority order):
1. `rst` or `flushE`: all E outputs go to 0.
2. Else if `stallD` or `div_stall` is 1: hold.
3. Else: load the decoded values.

Divide FSM states: IDLE, START, BUSY, DONE.
- `divE`: some `validE` lane holds an unserviced DIV/DIVU.
- IDLE: if `divE`, go to START and capture `div_signed`.
- START: `div_start`=1. Go to BUSY on the edge where `div_ready`=1.
- BUSY: go to DONE on the edge where `div_done`=1.
- DONE: go to IDLE on the edge where the E registers load, i.e. `stallD`=0. Otherwise stay in DONE. The serviced divide is never re-issued.
- `div_stall` = (state is START or BUSY) or (state is IDLE and `divE`).
- `flushE` in START or BUSY: `div_abort`=1 for that cycle, and the next state is IDLE.
- `rst`: next state is IDLE, no abort pulse.
- `div_done` in IDLE or START is ignored.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Decode latency: 1 cycle from D to E.
- `div_start` is registered (Moore) and stays high through START until `div_ready` is sampled.
- Minimum divide stall is 3 cycles: IDLE-detect, START, BUSY.
- Simultaneous `flushE` and `stallD`: flush wins.
- Simultaneous `div_done` and `flushE` in BUSY: flush wins, `div_abort`=1.

## Configuration
- `DECODE_CP0_EN` defined: MFC0, MTC0 and ERET decode as above.
- `DECODE_CP0_EN` undefined:
  - op COP0 sets invalid=1.
  - `cp0weE` is tied to 0.
  - No COP0 decode logic is generated.

## Structure
- Package `mips_dec_pkg` holds:
  - Opcode, funct, REGIMM-rt and COP0-rs constants.
  - Control-word localparams.
  - A `ctrl_t` packed struct for the 11 control bits.
  - The `dstate_t` enum.
- Sub-module `mips_decode_lane` is the combinational per-lane decoder, instantiated LANES times via generate.

## Test plan
- LW 0x8C220004 with `validD`=1 → next cycle: `controlE`=11'b10101100000, `hilo_weE`=00, `invalidE`=0.
- Undefined op 0xFC000000 → `invalidE`=1, `controlE`=0. With `DECODE_CP0_EN` undefined, MTC0 0x40826000 → `invalidE`=1, `cp0weE`=0.
- DIV 0x0062001A, `div_ready` after 2 cycles, `div_done` 5 cycles later:
  - `div_start`=1 and `div_signed`=1 until `div_ready` is sampled.
  - `div_stall` stays high until the DONE cycle.
  - E advances once, with no second `div_start`.
- `flushE` asserted during BUSY → one-cycle `div_abort`, state IDLE, E outputs 0.
- LANES=2 with DIVU in both lanes → lane0 served with `div_signed`=0; lane1 `invalidE`=1.
- `stallD` held 3 cycles with a new instruction on D → E holds the old values, then loads the new one on the first unstalled edge.

Source files
------------

// File: rtl/mips_dec_pkg.sv
// Shared MIPS ID-stage decode constants, control-word encodings and divider FSM states.
// Used by id_decode_pipe and mips_decode_lane; COP0 decode is gated by DECODE_CP0_EN.
package mips_dec_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f,
                         OP_COP0    = 6'h10, OP_LB     = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23,
                         OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_SB   = 6'h28, OP_SH   = 6'h29,
                         OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09,
                         FN_SYSCALL = 6'h0c, FN_BREAK = 6'h0d, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
                         FN_MFLO = 6'h12, FN_MTLO  = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                         FN_DIV  = 6'h1a, FN_DIVU  = 6'h1b, FN_ADD   = 6'h20, FN_ADDU  = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU  = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT   = 6'h2a, FN_SLTU  = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_ERET   = 5'h10;

  typedef struct packed {
    logic regwrite, regdst, alusrc, branch, memen, memtoreg, jump, jal, jr, bal, memwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE   = 11'b00000000000;
  localparam ctrl_t CTRL_RTYPE  = 11'b11000000000;
  localparam ctrl_t CTRL_JR     = 11'b00000010100;
  localparam ctrl_t CTRL_JALR   = 11'b11000000100;
  localparam ctrl_t CTRL_LOAD   = 11'b10101100000;
  localparam ctrl_t CTRL_STORE  = 11'b00101000001;
  localparam ctrl_t CTRL_BRANCH = 11'b00010000000;
  localparam ctrl_t CTRL_BAL    = 11'b10010000010;
  localparam ctrl_t CTRL_ALUI   = 11'b10100000000;
  localparam ctrl_t CTRL_J      = 11'b00000010000;
  localparam ctrl_t CTRL_JAL    = 11'b10000001000;
  localparam ctrl_t CTRL_MFC0   = 11'b10000000000;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_START = 2'd1,
    DS_BUSY  = 2'd2,
    DS_DONE  = 2'd3
  } dstate_t;

endpackage

// File: rtl/mips_decode_lane.sv
// Combinational single-lane MIPS decoder: control word, hilo/cp0 write enables, invalid flag.
// COP0 (MFC0/MTC0/ERET) decode only exists when DECODE_CP0_EN is defined.
module mips_decode_lane
  import mips_dec_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
`ifdef DECODE_CP0_EN
  output logic        cp0we,
`endif
  output logic [10:0] ctrl,
  output logic [1:0]  hilo_we,
  output logic        invalid,
  output logic        is_div,
  output logic        div_sgn
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  ctrl_t      c;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign fn = instr[5:0];

  logic unused_fields;
  assign unused_fields = ^{rs, instr[15:6]};

  always_comb begin
    c       = CTRL_NONE;
    hilo_we = 2'b00;
    invalid = 1'b0;
    is_div  = 1'b0;
    div_sgn = 1'b0;
`ifdef DECODE_CP0_EN
    cp0we   = 1'b0;
`endif
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:          c = CTRL_RTYPE;
          FN_MTHI:                  hilo_we = 2'b10;
          FN_MTLO:                  hilo_we = 2'b01;
          FN_MULT, FN_MULTU:        hilo_we = 2'b11;
          FN_DIV, FN_DIVU: begin
            hilo_we = 2'b11;
            is_div  = 1'b1;
            div_sgn = (fn == FN_DIV);
          end
          FN_JR:                    c = CTRL_JR;
          FN_JALR:                  c = CTRL_JALR;
          FN_SYSCALL, FN_BREAK:     ;
          default:                  invalid = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:         c = CTRL_BRANCH;
          RT_BLTZAL, RT_BGEZAL:     c = CTRL_BAL;
          default:                  invalid = 1'b1;
        endcase
      end
      OP_J:                         c = CTRL_J;
      OP_JAL:                       c = CTRL_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c = CTRL_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c = CTRL_ALUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: c = CTRL_LOAD;
      OP_SB, OP_SH, OP_SW:          c = CTRL_STORE;
`ifdef DECODE_CP0_EN
      OP_COP0: begin
        case (rs)
          RS_MFC0:                  c = CTRL_MFC0;
          RS_MTC0:                  cp0we = 1'b1;
          RS_ERET:                  ;
          default:                  invalid = 1'b1;
        endcase
      end
`endif
      default:                      invalid = 1'b1;
    endcase

    // An empty slot must not look like a reserved instruction or a divide.
    if (!valid) begin
      c       = CTRL_NONE;
      hilo_we = 2'b00;
      invalid = 1'b0;
      is_div  = 1'b0;
      div_sgn = 1'b0;
`ifdef DECODE_CP0_EN
      cp0we   = 1'b0;
`endif
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/id_decode_pipe.sv
// Multi-lane registered ID/EX decoder with stall/flush and a shared-divider handshake FSM.
// Define DECODE_CP0_EN to decode MFC0/MTC0/ERET; otherwise COP0 is reserved and cp0weE is 0.
module id_decode_pipe
  import mips_dec_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*32-1:0] instrD,
  input  logic [LANES-1:0]   validD,
  input  logic               stallD,
  input  logic               flushE,
  output logic [LANES*11-1:0] controlE,
  output logic [LANES*2-1:0] hilo_weE,
  output logic [LANES-1:0]   cp0weE,
  output logic [LANES-1:0]   invalidE,
  output logic [LANES-1:0]   validE,
  output logic               div_start,
  output logic               div_signed,
  input  logic               div_ready,
  input  logic               div_done,
  output logic               div_abort,
  output logic               div_stall
);

  logic [LANES-1:0][10:0] ctrl_d, ctrl_r, ctrl_q;
  logic [LANES-1:0][1:0]  hilo_d, hilo_r, hilo_q;
  logic [LANES-1:0]       inv_d, inv_r, inv_q, div_d, sgn_d, vld_q;
  logic                   div_any, div_sgn_r, div_pend_q, div_sgn_q, sgn_cap;
`ifdef DECODE_CP0_EN
  logic [LANES-1:0]       cp0_d, cp0_r, cp0_q;
`endif
  dstate_t                st, st_n;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mips_decode_lane u_lane (
      .instr   (instrD[32*i +: 32]),
      .valid   (validD[i]),
`ifdef DECODE_CP0_EN
      .cp0we   (cp0_d[i]),
`endif
      .ctrl    (ctrl_d[i]),
      .hilo_we (hilo_d[i]),
      .invalid (inv_d[i]),
      .is_div  (div_d[i]),
      .div_sgn (sgn_d[i])
    );
  end

  // One divider per group: only the lowest-index divide survives, later ones trap.
  always_comb begin
    ctrl_r    = ctrl_d;
    hilo_r    = hilo_d;
    inv_r     = inv_d;
`ifdef DECODE_CP0_EN
    cp0_r     = cp0_d;
`endif
    div_any   = 1'b0;
    div_sgn_r = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (div_d[i]) begin
        if (div_any) begin
          ctrl_r[i] = '0;
          hilo_r[i] = '0;
          inv_r[i]  = 1'b1;
`ifdef DECODE_CP0_EN
          cp0_r[i]  = 1'b0;
`endif
        end else begin
          div_any   = 1'b1;
          div_sgn_r = sgn_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      ctrl_q     <= '0;
      hilo_q     <= '0;
      inv_q      <= '0;
      vld_q      <= '0;
      div_pend_q <= 1'b0;
      div_sgn_q  <= 1'b0;
`ifdef DECODE_CP0_EN
      cp0_q      <= '0;
`endif
    end else if (!(stallD || div_stall)) begin
      ctrl_q     <= ctrl_r;
      hilo_q     <= hilo_r;
      inv_q      <= inv_r;
      vld_q      <= validD;
      div_pend_q <= div_any;
      div_sgn_q  <= div_sgn_r;
`ifdef DECODE_CP0_EN
      cp0_q      <= cp0_r;
`endif
    end
  end

  assign controlE = ctrl_q;
  assign hilo_weE = hilo_q;
  assign invalidE = inv_q;
  assign validE   = vld_q;
`ifdef DECODE_CP0_EN
  assign cp0weE   = cp0_q;
`else
  assign cp0weE   = '0;
`endif

  // DONE only releases together with an E load, so the serviced divide leaves E
  // on that same edge and is never seen again in IDLE.
  always_comb begin
    st_n = st;
    case (st)
      DS_IDLE:  if (div_pend_q && !flushE) st_n = DS_START;
      DS_START: if (flushE) st_n = DS_IDLE; else if (div_ready) st_n = DS_BUSY;
      DS_BUSY:  if (flushE) st_n = DS_IDLE; else if (div_done)  st_n = DS_DONE;
      DS_DONE:  if (!stallD) st_n = DS_IDLE;
      default:  st_n = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= DS_IDLE;
      sgn_cap <= 1'b0;
    end else begin
      st <= st_n;
      if (st == DS_IDLE && st_n == DS_START) sgn_cap <= div_sgn_q;
    end
  end

  assign div_start  = (st == DS_START);
  assign div_signed = sgn_cap;
  assign div_stall  = (st == DS_START) || (st == DS_BUSY) || (st == DS_IDLE && div_pend_q);
  assign div_abort  = !rst && flushE && ((st == DS_START) || (st == DS_BUSY));

endmodule

// File: tb/tb_id_decode_pipe.sv
// Self-checking bench for id_decode_pipe (LANES=2): directed decode/stall/divide scenarios plus
// a randomized decode run against a table-driven reference model. Honours DECODE_CP0_EN.
module tb_id_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] instrD;
  logic [1:0]  validD;
  logic        stallD, flushE, div_ready, div_done;
  logic [21:0] controlE;
  logic [3:0]  hilo_weE;
  logic [1:0]  cp0weE, invalidE, validE;
  logic        div_start, div_signed, div_abort, div_stall;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_MTC0 = 32'h40826000;
  localparam logic [31:0] I_DIV  = 32'h0062001A;
  localparam logic [31:0] I_DIVU = 32'h0062001B;
  localparam logic [31:0] I_ADDU = 32'h00430821;
  localparam logic [31:0] I_ORI  = 32'h34420001;

  id_decode_pipe #(.LANES(2)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .stallD(stallD), .flushE(flushE),
    .controlE(controlE), .hilo_weE(hilo_weE), .cp0weE(cp0weE), .invalidE(invalidE),
    .validE(validE), .div_start(div_start), .div_signed(div_signed), .div_ready(div_ready),
    .div_done(div_done), .div_abort(div_abort), .div_stall(div_stall)
  );

  always #5 clk = ~clk;

  wire [31:0] obs = {controlE, hilo_weE, cp0weE, invalidE, validE};

  // Reference decode straight from the instruction-class table: {inv, cp0we, hilo[1:0], ctrl[10:0]}.
  function automatic logic [14:0] ref_dec(input logic [31:0] ins, input logic v);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [10:0] c;
    logic [1:0]  h;
    logic        inv, cp;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    c = '0; h = '0; inv = 1'b0; cp = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: c = 11'b11000000000;
        6'h11: h = 2'b10;
        6'h13: h = 2'b01;
        6'h18, 6'h19, 6'h1a, 6'h1b: h = 2'b11;
        6'h08: c = 11'b00000010100;
        6'h09: c = 11'b11000000100;
        6'h0c, 6'h0d: ;
        default: inv = 1'b1;
      endcase
      6'h01: case (rt)
        5'h00, 5'h01: c = 11'b00010000000;
        5'h10, 5'h11: c = 11'b10010000010;
        default: inv = 1'b1;
      endcase
      6'h02: c = 11'b00000010000;
      6'h03: c = 11'b10000001000;
      6'h04, 6'h05, 6'h06, 6'h07: c = 11'b00010000000;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: c = 11'b10100000000;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = 11'b10101100000;
      6'h28, 6'h29, 6'h2b: c = 11'b00101000001;
`ifdef DECODE_CP0_EN
      6'h10: case (rs)
        5'h00: c = 11'b10000000000;
        5'h04: cp = 1'b1;
        5'h10: ;
        default: inv = 1'b1;
      endcase
`endif
      default: inv = 1'b1;
    endcase
    if (!v) return '0;
    return {inv, cp, h, c};
  endfunction

  function automatic logic is_div(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] == 6'h1a || ins[5:0] == 6'h1b);
  endfunction

  // Expected E contents for a 2-lane group, packed like obs.
  function automatic logic [31:0] ref_group(input logic [63:0] ins, input logic [1:0] v);
    logic [14:0] d [2];
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d[i] = ref_dec(ins[32*i +: 32], v[i]);
      if (v[i] && is_div(ins[32*i +: 32])) begin
        if (seen) d[i] = 15'h4000;
        seen = 1'b1;
      end
    end
    return {d[1][10:0], d[0][10:0], d[1][12:11], d[0][12:11], d[1][13], d[0][13],
            d[1][14], d[0][14], v};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  pool [0:19];
    logic [31:0] r;
    pool = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
             6'h07, 6'h09, 6'h0f, 6'h10, 6'h10, 6'h20, 6'h23, 6'h28, 6'h2b, 6'h3f};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[31:26] = pool[$urandom_range(0, 19)];
    if (r[31:26] == 6'h01 && $urandom_range(0, 3) != 0)
      r[20:16] = {($urandom_range(0, 1) == 1), 3'b000, ($urandom_range(0, 1) == 1)};
    if (r[31:26] == 6'h10 && $urandom_range(0, 3) != 0)
      r[25:21] = {($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 1) == 1), 2'b00};
    if (is_div(r)) r[5:0] = 6'h18;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instrD = {I_DIV, I_LW}; validD = 2'b11; stallD = 1'b0; flushE = 1'b0;
    div_ready = 1'b0; div_done = 1'b0;
    tick(); tick();
    tests++;
    if (obs !== 32'h0) begin
      $display("FAIL reset_e obs=%h expected=%h", obs, 32'h0); fails++;
    end
    tests++;
    if ({div_start, div_signed, div_abort, div_stall} !== 4'b0000) begin
      $display("FAIL reset_div got=%b expected=0000", {div_start, div_signed, div_abort, div_stall});
      fails++;
    end
    validD = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    instrD = {32'h0, I_LW}; validD = 2'b01;
    tick();
    tests++;
    if ({controlE[10:0], hilo_weE[1:0], invalidE, validE} !== {11'b10101100000, 2'b00, 2'b00, 2'b01}) begin
      $display("FAIL lw ctrl=%b hilo=%b inv=%b vld=%b expected ctrl=10101100000 hilo=00 inv=00 vld=01",
               controlE[10:0], hilo_weE[1:0], invalidE, validE);
      fails++;
    end
  endtask

  task automatic test_invalid();
    logic [3:0] exp;
`ifdef DECODE_CP0_EN
    exp = 4'b0110;  // {invalidE, cp0weE}: lane1 MTC0 writes cp0
`else
    exp = 4'b1100;
`endif
    instrD = {I_MTC0, I_BAD}; validD = 2'b11;
    tick();
    tests++;
    if (controlE[10:0] !== 11'b0 || hilo_weE[1:0] !== 2'b00) begin
      $display("FAIL bad_op ctrl=%b hilo=%b expected 0", controlE[10:0], hilo_weE[1:0]); fails++;
    end
    tests++;
    if ({invalidE, cp0weE} !== exp) begin
      $display("FAIL inv_cp0 got=%b expected=%b", {invalidE, cp0weE}, exp); fails++;
    end
    instrD = {I_BAD, I_LW}; validD = 2'b00;
    tick();
    tests++;
    if (obs !== 32'h0) begin
      $display("FAIL empty_slot obs=%h expected=0", obs); fails++;
    end
  endtask

  task automatic test_stall();
    instrD = {32'h0, I_LW}; validD = 2'b01; stallD = 1'b0;
    tick();
    instrD = {32'h0, I_ORI}; stallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (controlE[10:0] !== 11'b10101100000) begin
        $display("FAIL stall_hold cyc=%0d ctrl=%b expected=10101100000", k, controlE[10:0]); fails++;
      end
    end
    stallD = 1'b0;
    tick();
    tests++;
    if (controlE[10:0] !== 11'b10100000000) begin
      $display("FAIL stall_release ctrl=%b expected=10100000000", controlE[10:0]); fails++;
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    rst = 1'b1; validD = 2'b00; stallD = 1'b0; flushE = 1'b0;
    tick();
    rst = 1'b0;
    exp = '0;
    for (int n = 0; n < 300; n++) begin
      instrD = {rand_instr(), rand_instr()};
      validD = 2'($urandom);
      stallD = ($urandom_range(0, 3) == 0);
      flushE = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      if (flushE) exp = '0;
      else if (!stallD) exp = ref_group(instrD, validD);
      #1;
      tests++;
      if (obs !== exp || div_stall !== 1'b0 || div_start !== 1'b0) begin
        $display("FAIL random n=%0d instr=%h vld=%b obs=%h expected=%h div_stall=%b div_start=%b",
                 n, instrD, validD, obs, exp, div_stall, div_start);
        fails++;
      end
    end
    stallD = 1'b0; flushE = 1'b0; validD = 2'b00;
    tick();
  endtask

  task automatic test_div();
    instrD = {32'h0, I_DIV}; validD = 2'b01; stallD = 1'b0; flushE = 1'b0;
    div_ready = 1'b0; div_done = 1'b0;
    tick();
    tests++;
    if ({hilo_weE[1:0], controlE[10:0], invalidE, validE, div_stall, div_start} !==
        {2'b11, 11'b0, 2'b00, 2'b01, 1'b1, 1'b0}) begin
      $display("FAIL div_detect hilo=%b ctrl=%b inv=%b vld=%b stall=%b start=%b",
               hilo_weE[1:0], controlE[10:0], invalidE, validE, div_stall, div_start);
      fails++;
    end
    instrD = {32'h0, I_ADDU};
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if ({div_start, div_signed, div_stall, hilo_weE[1:0]} !== 5'b11111) begin
        $display("FAIL div_start cyc=%0d start=%b signed=%b stall=%b hilo=%b expected 1 1 1 11",
                 k, div_start, div_signed, div_stall, hilo_weE[1:0]);
        fails++;
      end
    end
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({div_start, div_stall, hilo_weE[1:0]} !== 4'b0111) begin
        $display("FAIL div_busy cyc=%0d start=%b stall=%b hilo=%b expected 0 1 11",
                 k, div_start, div_stall, hilo_weE[1:0]);
        fails++;
      end
      if (k == 4) div_done = 1'b1;
      tick();
    end
    div_done = 1'b0;
    tests++;
    if ({div_start, div_stall, hilo_weE[1:0]} !== 4'b0011) begin
      $display("FAIL div_done_cyc start=%b stall=%b hilo=%b expected 0 0 11",
               div_start, div_stall, hilo_weE[1:0]);
      fails++;
    end
    tick();
    tests++;
    if ({controlE[10:0], hilo_weE[1:0], div_start, div_stall} !== {11'b11000000000, 2'b00, 2'b00}) begin
      $display("FAIL div_advance ctrl=%b hilo=%b start=%b stall=%b expected 11000000000 00 0 0",
               controlE[10:0], hilo_weE[1:0], div_start, div_stall);
      fails++;
    end
    tick();
    tests++;
    if ({div_start, div_stall} !== 2'b00) begin
      $display("FAIL div_reissue start=%b stall=%b expected 00", div_start, div_stall); fails++;
    end
  endtask

  task automatic test_div_abort();
    instrD = {32'h0, I_DIV}; validD = 2'b01;
    tick(); tick();
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0;
    instrD = {32'h0, I_ADDU}; flushE = 1'b1; div_done = 1'b1;
    #1;
    tests++;
    if (div_abort !== 1'b1) begin
      $display("FAIL abort_pulse div_abort=%b expected=1", div_abort); fails++;
    end
    tick();
    flushE = 1'b0; div_done = 1'b0;
    #1;
    tests++;
    if ({obs, div_abort, div_stall, div_start} !== 35'h0) begin
      $display("FAIL abort_after obs=%h abort=%b stall=%b start=%b expected all 0",
               obs, div_abort, div_stall, div_start);
      fails++;
    end
    tick();
    tests++;
    if ({controlE[10:0], div_start, div_stall} !== {11'b11000000000, 2'b00}) begin
      $display("FAIL abort_resume ctrl=%b start=%b stall=%b expected 11000000000 0 0",
               controlE[10:0], div_start, div_stall);
      fails++;
    end
  endtask

  task automatic test_two_divu();
    instrD = {I_DIVU, I_DIVU}; validD = 2'b11;
    tick();
    tests++;
    if ({hilo_weE, invalidE, controlE, validE, div_stall} !== {4'b0011, 2'b10, 22'b0, 2'b11, 1'b1}) begin
      $display("FAIL divu_pair hilo=%b inv=%b ctrl=%h vld=%b stall=%b expected 0011 10 0 11 1",
               hilo_weE, invalidE, controlE, validE, div_stall);
      fails++;
    end
    instrD = {32'h0, I_ADDU}; validD = 2'b01;
    tick();
    tests++;
    if ({div_start, div_signed} !== 2'b10) begin
      $display("FAIL divu_start start=%b signed=%b expected 1 0", div_start, div_signed); fails++;
    end
    div_ready = 1'b1;
    tick();
    div_ready = 1'b0; div_done = 1'b1;
    tick();
    div_done = 1'b0;
    tick();
    tests++;
    if ({div_start, div_stall, invalidE, validE, controlE[10:0]} !==
        {2'b00, 2'b00, 2'b01, 11'b11000000000}) begin
      $display("FAIL divu_finish start=%b stall=%b inv=%b vld=%b ctrl=%b",
               div_start, div_stall, invalidE, validE, controlE[10:0]);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_invalid();
    test_stall();
    test_random();
    test_div();
    test_div_abort();
    test_two_divu();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
